ir_nec_rx: RTL and testbench

- NEC-protocol infrared frame decoder; the upstream stage of the IR-to-beeper path.
- Samples the raw demodulated receiver pin, times its low/high pulse widths, and assembles the 32-bit NEC frame (addr, ~addr, cmd, ~cmd, each LSB first).
- Presents the 8-bit command byte that the beeper stage consumes as its key code, plus valid/repeat/error strobes.

---
 rtl/ir_nec_rx.sv | 184 ++++++++++++++++++
 tb/tb_ir_nec_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_nec_rx.sv
// NEC infrared frame decoder: times synchronized IR_DATA pulse widths and assembles the 32-bit frame.
// Optional build macro IR_NEC_CHECK_EN enables the address/command complement-byte check in DONE.
module ir_nec_rx #(
    parameter int TICK_DIV   = 500,
    parameter int LEAD_L_MIN = 800,
    parameter int LEAD_L_MAX = 1000,
    parameter int LEAD_H_MIN = 400,
    parameter int LEAD_H_MAX = 500,
    parameter int REP_H_MIN  = 200,
    parameter int REP_H_MAX  = 250,
    parameter int BURST_MIN  = 40,
    parameter int BURST_MAX  = 70,
    parameter int ZERO_MIN   = 40,
    parameter int ZERO_MAX   = 70,
    parameter int ONE_MIN    = 140,
    parameter int ONE_MAX    = 190
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic       IR_DATA,
    output logic [7:0] o_ir_data,
    output logic [7:0] o_ir_addr,
    output logic       o_valid,
    output logic       o_repeat,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_L, S_LEAD_H, S_BIT_L, S_BIT_H, S_STOP_L, S_REP_STOP, S_DONE
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [10:0] width_q, width_d;
    logic [31:0] sr_q, sr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  ir_data_q, ir_data_d;
    logic [7:0]  ir_addr_q, ir_addr_d;
    logic        valid_q, valid_d;
    logic        repeat_q, repeat_d;
    logic        err_q, err_d;

    logic tick, fall, rise, timeout, frame_ok;

    function automatic logic in_win(input logic [10:0] w, input int lo, input int hi);
        return (int'(w) >= lo) && (int'(w) <= hi);
    endfunction

    // Largest legal width of the phase currently being timed.
    function automatic int phase_max(input state_t s);
        int m;
        case (s)
            S_LEAD_L: m = LEAD_L_MAX;
            S_LEAD_H: m = LEAD_H_MAX;
            S_BIT_H:  m = ONE_MAX;
            default:  m = BURST_MAX;
        endcase
        return m;
    endfunction

    assign fall    = sync_q[2] & ~sync_q[1];
    assign rise    = ~sync_q[2] & sync_q[1];
    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign timeout = (state_q != S_IDLE) && (state_q != S_DONE) &&
                     (int'(width_q) > phase_max(state_q));

`ifdef IR_NEC_CHECK_EN
    assign frame_ok = (sr_q[15:8] == ~sr_q[7:0]) && (sr_q[31:24] == ~sr_q[23:16]);
`else
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[1:0], IR_DATA};
        presc_d   = tick ? '0 : presc_q + PW'(1);
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ir_data_d = ir_data_q;
        ir_addr_d = ir_addr_q;
        valid_d   = 1'b0;
        repeat_d  = 1'b0;
        err_d     = 1'b0;

        if (timeout) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (fall) state_d = S_LEAD_L;
                S_LEAD_L: if (rise) begin
                    if (in_win(width_q, LEAD_L_MIN, LEAD_L_MAX)) state_d = S_LEAD_H;
                    else begin err_d = 1'b1; state_d = S_IDLE; end
                end
                S_LEAD_H: if (fall) begin
                    if (in_win(width_q, LEAD_H_MIN, LEAD_H_MAX)) begin
                        cnt_d   = '0;
                        state_d = S_BIT_L;
                    end else if (in_win(width_q, REP_H_MIN, REP_H_MAX)) begin
                        state_d = S_REP_STOP;
                    end else begin
                        err_d = 1'b1; state_d = S_IDLE;
                    end
                end
                S_BIT_L: if (rise) begin
                    if (in_win(width_q, BURST_MIN, BURST_MAX)) state_d = S_BIT_H;
                    else begin err_d = 1'b1; state_d = S_IDLE; end
                end
                S_BIT_H: if (fall) begin
                    if (in_win(width_q, ZERO_MIN, ZERO_MAX) || in_win(width_q, ONE_MIN, ONE_MAX)) begin
                        // New bit enters at the MSB so the first bit received ends up in bit 0.
                        sr_d    = {in_win(width_q, ONE_MIN, ONE_MAX), sr_q[31:1]};
                        cnt_d   = cnt_q + 6'd1;
                        state_d = (cnt_q == 6'd31) ? S_STOP_L : S_BIT_L;
                    end else begin
                        err_d = 1'b1; state_d = S_IDLE;
                    end
                end
                S_STOP_L: if (rise) begin
                    if (in_win(width_q, BURST_MIN, BURST_MAX)) state_d = S_DONE;
                    else begin err_d = 1'b1; state_d = S_IDLE; end
                end
                S_REP_STOP: if (rise) begin
                    if (in_win(width_q, BURST_MIN, BURST_MAX)) repeat_d = 1'b1;
                    else err_d = 1'b1;
                    state_d = S_IDLE;
                end
                S_DONE: begin
                    if (frame_ok) begin
                        ir_addr_d = sr_q[7:0];
                        ir_data_d = sr_q[23:16];
                        valid_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (fall || rise || (state_d != state_q)) width_d = '0;
        else if (tick && (width_q != 11'h7FF)) width_d = width_q + 11'd1;
        else width_d = width_q;
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_q   <= S_IDLE;
            sync_q    <= 3'b111;
            presc_q   <= '0;
            width_q   <= '0;
            sr_q      <= '0;
            cnt_q     <= '0;
            ir_data_q <= '0;
            ir_addr_q <= '0;
            valid_q   <= 1'b0;
            repeat_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            presc_q   <= presc_d;
            width_q   <= width_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ir_data_q <= ir_data_d;
            ir_addr_q <= ir_addr_d;
            valid_q   <= valid_d;
            repeat_q  <= repeat_d;
            err_q     <= err_d;
        end
    end

    assign o_ir_data = ir_data_q;
    assign o_ir_addr = ir_addr_q;
    assign o_valid   = valid_q;
    assign o_repeat  = repeat_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_ir_nec_rx.sv
// Bench for ir_nec_rx with a 1-cycle tick: a pulse held N+1 cycles is measured as N ticks.
module tb_ir_nec_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ir  = 1'b1;
    logic [7:0] o_ir_data, o_ir_addr;
    logic       o_valid, o_repeat, o_err;

    ir_nec_rx #(.TICK_DIV(1)) dut (
        .CLK_50M(clk), .RST(rst), .IR_DATA(ir),
        .o_ir_data(o_ir_data), .o_ir_addr(o_ir_addr),
        .o_valid(o_valid), .o_repeat(o_repeat), .o_err(o_err)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] K_VALID = 3'b001, K_REP = 3'b010, K_ERR = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        logic [7:0] addr;
        int         lat;
    } exp_t;

    typedef struct {
        logic [31:0] w;
        int          ll, lh, bu, ze, on;
        logic [2:0]  kind;
        logic [7:0]  data, addr;
    } vec_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         rise_cyc = 0;
    logic       skip_dc  = 1'b1;
    logic [7:0] prev_data = 8'h00, prev_addr = 8'h00;
    logic [7:0] cur_data = 8'h00, cur_addr = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input logic [7:0] a, input logic [7:0] ia,
                                        input logic [7:0] c, input logic [7:0] ic);
        return {ic, c, ia, a};
    endfunction

    task automatic push(input logic [2:0] k, input logic [7:0] d, input logic [7:0] a, input int lat);
        exp_t x;
        x.kind = k; x.data = d; x.addr = a; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic low(input int t);
        ir = 1'b0;
        repeat (t + 1) @(negedge clk);
    endtask

    task automatic high(input int t);
        ir = 1'b1;
        rise_cyc = cyc;
        repeat (t + 1) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input int bu, input int ze, input int on);
        for (int i = 0; i < n; i++) begin
            low(bu);
            high(w[i] ? on : ze);
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int ll, input int lh,
                              input int bu, input int ze, input int on);
        low(ll);
        high(lh);
        send_bits(w, 32, bu, ze, on);
        low(bu);
        high(30);
    endtask

    // Strobe scoreboard plus the rule that outputs only move together with o_valid.
    always @(negedge clk) begin
        if (o_valid || o_repeat || o_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {o_err, o_repeat, o_valid}, 0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", {o_err, o_repeat, o_valid}, e.kind);
                if (e.kind == K_VALID) begin
                    chk("ir_data", o_ir_data, e.data);
                    chk("ir_addr", o_ir_addr, e.addr);
                end
                if (e.lat >= 0) chk("strobe_latency", cyc - rise_cyc, e.lat);
            end
        end
        if (!skip_dc && ((o_ir_data != prev_data) || (o_ir_addr != prev_addr)))
            chk("out_change_needs_valid", o_valid, 1);
        prev_data = o_ir_data;
        prev_addr = o_ir_addr;
    end

    vec_t vecs[5];

    initial begin
        // Valid/err-in-DONE: 2 sync flops + STOP_L->DONE + output register = 4 cycles after rise.
        vecs[0] = '{mkw(8'h00, 8'hFF, 8'h45, 8'hBA), 900, 450, 56, 56, 169, K_VALID, 8'h45, 8'h00};
        vecs[1] = '{mkw(8'h00, 8'hFF, 8'h45, 8'hBA), 1000, 500, 64, 64, 190, K_VALID, 8'h45, 8'h00};
        vecs[2] = '{mkw(8'h34, 8'hCB, 8'h12, 8'hED), 800, 400, 40, 40, 140, K_VALID, 8'h12, 8'h34};
`ifdef IR_NEC_CHECK_EN
        vecs[3] = '{mkw(8'h00, 8'hFF, 8'h16, 8'hE0), 900, 450, 56, 56, 169, K_ERR, 8'h00, 8'h00};
        vecs[4] = '{mkw(8'h12, 8'h99, 8'hA7, 8'h58), 900, 450, 56, 56, 169, K_ERR, 8'h00, 8'h00};
`else
        vecs[3] = '{mkw(8'h00, 8'hFF, 8'h16, 8'hE0), 900, 450, 56, 56, 169, K_VALID, 8'h16, 8'h00};
        vecs[4] = '{mkw(8'h12, 8'h99, 8'hA7, 8'h58), 900, 450, 56, 56, 169, K_VALID, 8'hA7, 8'h12};
`endif

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ir_data", o_ir_data, 0);
        chk("reset_ir_addr", o_ir_addr, 0);
        chk("reset_strobes", {o_err, o_repeat, o_valid}, 0);
        skip_dc = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            push(vecs[i].kind, vecs[i].data, vecs[i].addr, 4);
            send_frame(vecs[i].w, vecs[i].ll, vecs[i].lh, vecs[i].bu, vecs[i].ze, vecs[i].on);
            if (vecs[i].kind == K_VALID) begin
                cur_data = vecs[i].data;
                cur_addr = vecs[i].addr;
            end
        end
        chk("table_data_hold", o_ir_data, cur_data);

        // Repeat frame: strobe registered one cycle after the synchronized rise (3 after drive).
        low(900);
        high(225);
        push(K_REP, 8'h00, 8'h00, 3);
        low(56);
        high(30);
        chk("repeat_data_hold", o_ir_data, cur_data);

        // 5 ms leader low is rejected at its rise.
        push(K_ERR, 8'h00, 8'h00, 3);
        low(500);
        high(30);
        chk("bad_leader_data_hold", o_ir_data, cur_data);
        chk("bad_leader_addr_hold", o_ir_addr, cur_addr);

        // 39-tick first burst falls just below the burst window.
        low(900);
        high(450);
        push(K_ERR, 8'h00, 8'h00, 3);
        low(39);
        high(30);

        // Leader high held past LEAD_H_MAX: timeout once width reaches 501 (3 + 501 + 1 cycles).
        low(900);
        push(K_ERR, 8'h00, 8'h00, 505);
        high(600);

        // 16 bursts, then line stays high: BIT_H timeout at width 191 (3 + 191 + 1 cycles).
        low(900);
        high(450);
        send_bits(mkw(8'h00, 8'hFF, 8'h0C, 8'hF3), 15, 56, 56, 169);
        low(56);
        push(K_ERR, 8'h00, 8'h00, 195);
        high(2000);
        push(K_VALID, 8'h0C, 8'h00, 4);
        send_frame(mkw(8'h00, 8'hFF, 8'h0C, 8'hF3), 900, 450, 56, 56, 169);
        chk("after_timeout_data", o_ir_data, 8'h0C);

        // One-cycle reset during the space of bit 10.
        low(900);
        high(450);
        send_bits(mkw(8'h5A, 8'hA5, 8'h3C, 8'hC3), 10, 56, 56, 169);
        low(56);
        high(20);
        skip_dc = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_ir_data", o_ir_data, 0);
        chk("midreset_ir_addr", o_ir_addr, 0);
        chk("midreset_strobes", {o_err, o_repeat, o_valid}, 0);
        skip_dc = 1'b0;
        high(300);
        push(K_VALID, 8'h3C, 8'h5A, 4);
        send_frame(mkw(8'h5A, 8'hA5, 8'h3C, 8'hC3), 900, 450, 56, 56, 169);
        chk("after_reset_data", o_ir_data, 8'h3C);
        chk("after_reset_addr", o_ir_addr, 8'h5A);

        high(50);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
